// File: rtl/regfl_wr_sched_pkg.sv
// Package shared by the register-file write-port scheduler.
//   state_e       : scheduler FSM states (IDLE, CLEAR)
//   CLIENT_IDX_W  : client index width for the default client count
//   idx_width()   : client index width for any client count (minimum 1 bit)
package regfl_wr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_CLIENT_COUNT = 4;
  localparam int unsigned CLIENT_IDX_W         = $clog2(DEFAULT_CLIENT_COUNT);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfl_wr_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   eligible_i : requesters that may win this cycle
//   ptr_i      : highest-priority index (search starts here, wrapping)
//   grant_o    : one-hot winner (all zero when nothing eligible)
//   winner_o   : winner index (zero when nothing eligible)
//   valid_o    : at least one requester eligible
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW:0]    sum;

  // Rotate so that bit 0 of 'rotated' is the pointer position; the first set
  // bit then sits at an offset from the pointer that is mapped back modulo N.
  assign doubled = {eligible_i, eligible_i};
  assign rotated = N'(doubled >> ptr_i);

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    sum      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid_o && rotated[k]) begin
        valid_o = 1'b1;
        sum     = {1'b0, ptr_i} + (IW+1)'(k);
        if (sum >= (IW+1)'(N)) begin
          sum = sum - (IW+1)'(N);
        end
        winner_o = sum[IW-1:0];
      end
    end
    if (valid_o) begin
      grant_o = N'(1) << winner_o;
    end
  end

endmodule

// File: rtl/regfl_wr_sched.sv
// Write-port scheduler for the 8x64 register file.
// Shares the single write port among client_count requesters with
// round-robin arbitration (valid/grant handshake) and runs a hardware clear
// sweep that writes zero to every register.
//
// Ports:
//   clk, rst_b       : clock (rising edge), asynchronous active-low reset
//   req              : per-client level request, held until gnt
//   req_addr/req_data: packed per-client address / data
//   gnt              : one-hot, one-cycle grant; the write is on the port now
//   clr_start        : pulse to start the clear sweep (ignored while sweeping)
//   clr_busy         : high while the sweep drives the port
//   clr_done         : one-cycle pulse after the last clear write
//   rf_address/rf_d/rf_enable : connect 1:1 to the register file
//
// Optional build macro REGFL_WR_SCHED_PROTECT_EN adds:
//   wr_protect       : per-register write protection (client writes only)
//   prot_err         : pulses in the gnt cycle of a blocked write
module regfl_wr_sched
  import regfl_wr_sched_pkg::*;
#(
  parameter int unsigned address_width  = 3,
  parameter int unsigned register_count = 2**address_width,
  parameter int unsigned data_width     = 64,
  parameter int unsigned client_count   = 4
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [client_count-1:0]            req,
  input  logic [client_count*address_width-1:0] req_addr,
  input  logic [client_count*data_width-1:0] req_data,
  output logic [client_count-1:0]            gnt,
  input  logic                               clr_start,
  output logic                               clr_busy,
  output logic                               clr_done,
  output logic [address_width-1:0]           rf_address,
  output logic [data_width-1:0]              rf_d,
  output logic                               rf_enable
`ifdef REGFL_WR_SCHED_PROTECT_EN
  ,
  input  logic [register_count-1:0]          wr_protect,
  output logic                               prot_err
`endif
);

  localparam int unsigned IW = idx_width(client_count);
  localparam logic [address_width-1:0] LAST_ADDR = address_width'(register_count - 1);
  localparam logic [IW-1:0]            LAST_CL   = IW'(client_count - 1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [client_count-1:0]  gnt_q, gnt_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]    data_q, data_d;
  logic                     en_q, en_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef REGFL_WR_SCHED_PROTECT_EN
  logic                     perr_q, perr_d;
`endif

  logic [client_count-1:0]  eligible;
  logic [client_count-1:0]  arb_grant;
  logic [IW-1:0]            arb_winner;
  logic                     arb_valid;
  logic [address_width-1:0] win_addr;
  logic [data_width-1:0]    win_data;

  logic [address_width-1:0] cl_addr [client_count];
  logic [data_width-1:0]    cl_data [client_count];

  for (genvar i = 0; i < client_count; i++) begin : g_unpack
    assign cl_addr[i] = req_addr[i*address_width +: address_width];
    assign cl_data[i] = req_data[i*data_width +: data_width];
  end

  // A client on the port this cycle still holds req; masking it keeps it
  // from being granted twice for the same write.
  assign eligible = req & ~gnt_q;

  rr_arbiter #(
    .N  (client_count),
    .IW (IW)
  ) u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .winner_o   (arb_winner),
    .valid_o    (arb_valid)
  );

  assign win_addr = cl_addr[arb_winner];
  assign win_data = cl_data[arb_winner];

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_start)           state_d = CLEAR;
      CLEAR:   if (addr_q == LAST_ADDR) state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    gnt_d  = '0;
    en_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    ptr_d  = ptr_q;
`ifdef REGFL_WR_SCHED_PROTECT_EN
    perr_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          busy_d = 1'b1;
          en_d   = 1'b1;
          addr_d = '0;
          data_d = '0;
        end else if (arb_valid) begin
          gnt_d  = arb_grant;
          addr_d = win_addr;
          data_d = win_data;
          ptr_d  = (arb_winner == LAST_CL) ? '0 : arb_winner + IW'(1);
`ifdef REGFL_WR_SCHED_PROTECT_EN
          en_d   = ~wr_protect[win_addr];
          perr_d = wr_protect[win_addr];
`else
          en_d   = 1'b1;
`endif
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          en_d   = 1'b1;
          addr_d = addr_q + address_width'(1);
          data_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef REGFL_WR_SCHED_PROTECT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign prot_err = perr_q;
`endif

  assign gnt        = gnt_q;
  assign clr_busy   = busy_q;
  assign clr_done   = done_q;
  assign rf_address = addr_q;
  assign rf_d       = data_q;
  assign rf_enable  = en_q;

endmodule

// File: tb/tb_regfl_wr_sched.sv
// Self-checking bench for regfl_wr_sched: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model of the scheduler
// and a model of the register file it feeds.
module tb_regfl_wr_sched;

  localparam int AW = 3;
  localparam int RC = 8;
  localparam int DW = 64;
  localparam int NC = 4;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [NC-1:0]     req;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_data;
  logic [NC-1:0]     gnt;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [AW-1:0]     rf_address;
  logic [DW-1:0]     rf_d;
  logic              rf_enable;
`ifdef REGFL_WR_SCHED_PROTECT_EN
  logic [RC-1:0]     wr_protect;
  logic              prot_err;
`endif

  always #5 clk = ~clk;

  regfl_wr_sched #(
    .address_width  (AW),
    .register_count (RC),
    .data_width     (DW),
    .client_count   (NC)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .rf_address (rf_address),
    .rf_d       (rf_d),
    .rf_enable  (rf_enable)
`ifdef REGFL_WR_SCHED_PROTECT_EN
    ,
    .wr_protect (wr_protect),
    .prot_err   (prot_err)
`endif
  );

  // Register file fed by the DUT's write port
  logic [DW-1:0] dut_rf [RC] = '{default: '0};
  always @(posedge clk) if (rf_enable === 1'b1) dut_rf[rf_address] <= rf_d;

  int checks = 0;
  int errors = 0;

  // Expected register file contents
  logic [DW-1:0] exp_rf [RC] = '{default: '0};

  // Behavioural model of the scheduler
  bit            m_clear;
  int            m_ptr, m_gnt, m_sweep;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d;
  bit            m_en, m_busy, m_done, m_perr;

  // Client state
  int            cl_rem  [NC];
  bit            cl_rand [NC];
  logic [AW-1:0] cl_addr [NC];
  logic [DW-1:0] cl_data [NC];
  int            prev_mgnt;

  task automatic model_reset();
    m_clear = 0; m_ptr = 0; m_gnt = -1; m_sweep = 0;
    m_addr = '0; m_d = '0; m_en = 0; m_busy = 0; m_done = 0; m_perr = 0;
    prev_mgnt = -1;
  endtask

  task automatic drive_clients();
    for (int i = 0; i < NC; i++) begin
      req[i]                 = (cl_rem[i] > 0);
      req_addr[i*AW +: AW]   = cl_addr[i];
      req_data[i*DW +: DW]   = cl_data[i];
    end
  endtask

  task automatic clients_idle();
    for (int i = 0; i < NC; i++) begin
      cl_rem[i] = 0; cl_rand[i] = 0; cl_addr[i] = '0; cl_data[i] = '0;
    end
    drive_clients();
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom} | 64'h1;
  endfunction

  // One clock: predict, advance, compare every output, let clients react.
  task automatic tick();
    bit            n_clear, n_en, n_busy, n_done, n_perr, prot;
    int            n_ptr, n_gnt, n_sweep, w, c;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_d;
    logic [NC-1:0] eg;
    n_clear = m_clear; n_ptr = m_ptr; n_gnt = -1; n_sweep = m_sweep;
    n_addr = m_addr; n_d = m_d; n_en = 0; n_busy = 0; n_done = 0; n_perr = 0;
    prot = 0;
    if (!m_clear) begin
      if (clr_start) begin
        n_clear = 1; n_sweep = 0; n_busy = 1; n_en = 1; n_addr = '0; n_d = '0;
      end else begin
        w = -1;
        for (int k = 0; k < NC; k++) begin
          c = (m_ptr + k) % NC;
          if (w < 0 && req[c] && c != m_gnt) w = c;
        end
        if (w >= 0) begin
          n_gnt  = w;
          n_addr = req_addr[w*AW +: AW];
          n_d    = req_data[w*DW +: DW];
          n_ptr  = (w + 1) % NC;
`ifdef REGFL_WR_SCHED_PROTECT_EN
          prot   = wr_protect[n_addr];
`endif
          n_en   = !prot;
          n_perr = prot;
        end
      end
    end else begin
      if (m_sweep == RC - 1) begin
        n_clear = 0; n_done = 1;
      end else begin
        n_sweep = m_sweep + 1; n_busy = 1; n_en = 1;
        n_addr = AW'(n_sweep); n_d = '0;
      end
    end

    @(posedge clk);
    if (rst_b) begin
      if (m_en) exp_rf[m_addr] = m_d;
      m_clear = n_clear; m_ptr = n_ptr; m_gnt = n_gnt; m_sweep = n_sweep;
      m_addr = n_addr; m_d = n_d; m_en = n_en; m_busy = n_busy;
      m_done = n_done; m_perr = n_perr;
    end else begin
      model_reset();
    end
    #1;
    eg = (m_gnt >= 0) ? (NC'(1) << m_gnt) : '0;
    checks++; if (gnt !== eg)             begin errors++; $display("FAIL gnt @%0t: got %b expected %b", $time, gnt, eg); end
    checks++; if (rf_enable !== m_en)     begin errors++; $display("FAIL rf_enable @%0t: got %b expected %b", $time, rf_enable, m_en); end
    checks++; if (rf_address !== m_addr)  begin errors++; $display("FAIL rf_address @%0t: got %0d expected %0d", $time, rf_address, m_addr); end
    checks++; if (rf_d !== m_d)           begin errors++; $display("FAIL rf_d @%0t: got %h expected %h", $time, rf_d, m_d); end
    checks++; if (clr_busy !== m_busy)    begin errors++; $display("FAIL clr_busy @%0t: got %b expected %b", $time, clr_busy, m_busy); end
    checks++; if (clr_done !== m_done)    begin errors++; $display("FAIL clr_done @%0t: got %b expected %b", $time, clr_done, m_done); end
`ifdef REGFL_WR_SCHED_PROTECT_EN
    checks++; if (prot_err !== m_perr)    begin errors++; $display("FAIL prot_err @%0t: got %b expected %b", $time, prot_err, m_perr); end
`endif
    // A client that saw gnt in the previous cycle now drops or changes its request
    if (prev_mgnt >= 0 && cl_rem[prev_mgnt] > 0) begin
      cl_rem[prev_mgnt]--;
      if (cl_rand[prev_mgnt]) begin
        cl_addr[prev_mgnt] = AW'($urandom_range(RC - 1));
        cl_data[prev_mgnt] = rnd64();
      end
    end
    prev_mgnt = m_gnt;
    drive_clients();
  endtask

  task automatic do_reset();
    clients_idle();
    clr_start = 0;
    rst_b = 0;
    tick();
    tick();
    rst_b = 1;
  endtask

  task automatic wait_clients_idle(input string tag);
    int guard;
    bit busy;
    guard = 0;
    busy  = 1;
    while (busy && guard < 200) begin
      busy = 0;
      for (int i = 0; i < NC; i++) if (cl_rem[i] > 0) busy = 1;
      if (busy) tick();
      guard++;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL %s drain: clients still pending after %0d cycles, required 0 pending", tag, guard); end
    tick();
    tick();
  endtask

  // Write distinct nonzero data to every register through the clients.
  task automatic preload();
    for (int r = 0; r < RC / NC; r++) begin
      for (int i = 0; i < NC; i++) begin
        cl_rem[i] = 1; cl_rand[i] = 0;
        cl_addr[i] = AW'(r * NC + i);
        cl_data[i] = rnd64();
      end
      drive_clients();
      wait_clients_idle("preload");
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NC; i++) begin
      cl_rem[i] = 3; cl_rand[i] = 1; cl_addr[i] = AW'($urandom_range(RC - 1)); cl_data[i] = rnd64();
    end
    drive_clients();
    repeat (3) tick();
    #2;
    rst_b = 0;
    #1;
    checks++;
    if ({gnt, rf_enable, clr_busy, clr_done} !== '0 || rf_address !== '0 || rf_d !== '0) begin
      errors++;
      $display("FAIL async_reset: got gnt=%b en=%b busy=%b done=%b addr=%0d d=%h required all zero",
               gnt, rf_enable, clr_busy, clr_done, rf_address, rf_d);
    end
    clients_idle();
    model_reset();
    tick();
    rst_b = 1;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_after_reset: got gnt=%b required 0000", gnt); end
    cl_rem[2] = 1; cl_addr[2] = 3'd3; cl_data[2] = rnd64();
    drive_clients();
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL first_gnt_after_reset: got %b required 0100", gnt); end
    wait_clients_idle("reset");
  endtask

  task automatic test_single_client();
    do_reset();
    cl_rem[1] = 3; cl_rand[1] = 0; cl_addr[1] = 3'd5; cl_data[1] = 64'hDEAD;
    drive_clients();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (gnt !== ((k % 2 == 0) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL single_alternate cycle %0d: got gnt=%b required %b", k, gnt, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      end
    end
    wait_clients_idle("single");
    checks++; if (dut_rf[5] !== 64'hDEAD) begin errors++; $display("FAIL single_reg5: got %h required %h", dut_rf[5], 64'hDEAD); end
  endtask

  task automatic test_all_clients();
    logic [DW-1:0] want [NC];
    do_reset();
    for (int i = 0; i < NC; i++) begin
      cl_rem[i] = 3; cl_rand[i] = 0; cl_addr[i] = AW'(2 * i + 1); cl_data[i] = rnd64();
      want[i] = cl_data[i];
    end
    drive_clients();
    for (int k = 0; k < 3 * NC; k++) begin
      tick();
      checks++;
      if (gnt !== (NC'(1) << (k % NC))) begin
        errors++; $display("FAIL rr_order cycle %0d: got gnt=%b required %b", k, gnt, NC'(1) << (k % NC));
      end
    end
    wait_clients_idle("all_clients");
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (dut_rf[2 * i + 1] !== want[i]) begin
        errors++; $display("FAIL all_clients_reg%0d: got %h required %h", 2 * i + 1, dut_rf[2 * i + 1], want[i]);
      end
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] pre [RC];
    do_reset();
    preload();
    for (int a = 0; a < RC; a++) pre[a] = exp_rf[a];
    for (int a = 0; a < RC; a++) begin
      checks++; if (dut_rf[a] !== pre[a]) begin errors++; $display("FAIL preload_reg%0d: got %h required %h", a, dut_rf[a], pre[a]); end
    end
    for (int i = 0; i < NC; i++) begin
      cl_rem[i] = 2; cl_rand[i] = 1; cl_addr[i] = AW'($urandom_range(RC - 1)); cl_data[i] = rnd64();
    end
    drive_clients();
    clr_start = 1;
    for (int k = 0; k < RC; k++) begin
      tick();
      clr_start = (k == 2);
      checks++;
      if (clr_busy !== 1'b1 || rf_address !== AW'(k) || gnt !== '0 || rf_enable !== 1'b1) begin
        errors++; $display("FAIL sweep step %0d: got busy=%b addr=%0d gnt=%b en=%b required busy=1 addr=%0d gnt=0000 en=1",
                           k, clr_busy, rf_address, gnt, rf_enable, k);
      end
    end
    clr_start = 0;
    tick();
    checks++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || gnt !== '0 || rf_enable !== 1'b0) begin
      errors++; $display("FAIL sweep_end: got done=%b busy=%b gnt=%b en=%b required done=1 busy=0 gnt=0000 en=0",
                         clr_done, clr_busy, gnt, rf_enable);
    end
    for (int a = 0; a < RC; a++) begin
      checks++; if (dut_rf[a] !== '0) begin errors++; $display("FAIL cleared_reg%0d: got %h required 0", a, dut_rf[a]); end
    end
    tick();
    checks++; if (gnt !== 4'b0001 || clr_done !== 1'b0) begin errors++; $display("FAIL gnt_after_clear: got gnt=%b done=%b required gnt=0001 done=0", gnt, clr_done); end
    wait_clients_idle("clear");
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] pre [RC];
    do_reset();
    preload();
    for (int a = 0; a < RC; a++) pre[a] = exp_rf[a];
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (3) tick();
    checks++; if (rf_address !== 3'd3 || clr_busy !== 1'b1) begin errors++; $display("FAIL sweep_at_3: got addr=%0d busy=%b required addr=3 busy=1", rf_address, clr_busy); end
    #2;
    rst_b = 0;
    #1;
    checks++; if (clr_busy !== 1'b0 || rf_enable !== 1'b0) begin errors++; $display("FAIL reset_mid_clear: got busy=%b en=%b required 0 0", clr_busy, rf_enable); end
    model_reset();
    tick();
    rst_b = 1;
    tick();
    tick();
    for (int a = 0; a < RC; a++) begin
      if (a != 3) begin
        checks++;
        if (dut_rf[a] !== ((a < 3) ? '0 : pre[a])) begin
          errors++; $display("FAIL after_abort_reg%0d: got %h required %h", a, dut_rf[a], (a < 3) ? '0 : pre[a]);
        end
      end
    end
    // the aborted address-3 write is not guaranteed either way
    exp_rf[3] = dut_rf[3];
  endtask

  task automatic test_protect();
    logic [DW-1:0] old6, val;
    do_reset();
    old6 = exp_rf[6];
    val  = rnd64() ^ old6;
`ifdef REGFL_WR_SCHED_PROTECT_EN
    wr_protect = 8'b0100_0000;
`endif
    cl_rem[0] = 1; cl_rand[0] = 0; cl_addr[0] = 3'd6; cl_data[0] = val;
    drive_clients();
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL protect_gnt: got %b required 0001", gnt); end
    wait_clients_idle("protect");
`ifdef REGFL_WR_SCHED_PROTECT_EN
    checks++; if (dut_rf[6] !== old6) begin errors++; $display("FAIL protect_reg6: got %h required %h", dut_rf[6], old6); end
    wr_protect = '0;
`else
    checks++; if (dut_rf[6] !== val) begin errors++; $display("FAIL unprotected_reg6: got %h required %h", dut_rf[6], val); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (cl_rem[i] == 0 && $urandom_range(2) == 0) begin
          cl_rem[i] = $urandom_range(3, 1); cl_rand[i] = 1;
          cl_addr[i] = AW'($urandom_range(RC - 1)); cl_data[i] = rnd64();
        end
      end
`ifdef REGFL_WR_SCHED_PROTECT_EN
      if ($urandom_range(30) == 0) wr_protect = RC'($urandom);
`endif
      drive_clients();
      clr_start = ($urandom_range(40) == 0);
      tick();
    end
    clr_start = 0;
    wait_clients_idle("random");
    for (int a = 0; a < RC; a++) begin
      checks++; if (dut_rf[a] !== exp_rf[a]) begin errors++; $display("FAIL random_reg%0d: got %h required %h", a, dut_rf[a], exp_rf[a]); end
    end
  endtask

  initial begin
    rst_b     = 0;
    clr_start = 0;
`ifdef REGFL_WR_SCHED_PROTECT_EN
    wr_protect = '0;
`endif
    model_reset();
    clients_idle();
    test_reset();
    test_single_client();
    test_all_clients();
    test_clear();
    test_reset_mid_clear();
    test_protect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
